// File: rtl/clk_div_meas.sv
// clk_div_meas: decoder for a divided clock derived from clk_i.
// Recovers the division ratio and high time of meas_clk_i in clk_i cycles,
// reports a locked ratio after LOCK_CNT consecutive identical periods and
// raises a sticky error when no rising edge arrives within TIMEOUT cycles.
module clk_div_meas #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             meas_en_i,
    input  logic             meas_clk_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] div_num_o,
    output logic             lock_o,
    output logic             err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_CNT - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             sync_d;
    logic             rise;
    logic             fall;

    logic [1:0]       state_q;
    logic [1:0]       state_d;

    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] prev_per;
    logic [3:0]       match_cnt;

    logic             run;
    logic             measuring;
    logic             timeout;
    logic             per_eq_prev;
    logic [3:0]       match_nxt;
    logic             lock_hit;
    logic             per_mismatch;

    // Two-flop synchroniser for the clock under test plus one delay stage
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_d  <= 1'b0;
        end else begin
            sync_q1 <= meas_clk_i;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
        end
    end

    // Edge detection on the synchronised level
    always_comb begin
        rise = sync_q2 & ~sync_d;
        fall = ~sync_q2 & sync_d;
    end

    // Per-cycle status: timeout, period comparison and lock qualification.
    // A rise in the timeout cycle suppresses the timeout so that a period of
    // exactly TIMEOUT is still accepted.
    always_comb begin
        run          = meas_en_i && (state_q != ST_IDLE);
        measuring    = (state_q == ST_TRACK) || (state_q == ST_LOCK);
        timeout      = run && !rise && (per_cnt >= TIMEOUT_C);
        per_eq_prev  = (per_cnt == prev_per);
        match_nxt    = per_eq_prev ? (match_cnt + 4'd1) : '0;
        lock_hit     = (match_nxt >= LOCK_TGT);
        per_mismatch = (per_cnt != div_num_o);
    end

    // Next-state selection; dropping meas_en_i overrides everything
    always_comb begin
        state_d = state_q;
        if (!meas_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (rise && lock_hit) begin
                        state_d = ST_LOCK;
                    end else if (timeout) begin
                        state_d = ST_ARM;
                    end
                end
                ST_LOCK: begin
                    if (rise && per_mismatch) begin
                        state_d = ST_TRACK;
                    end else if (timeout) begin
                        state_d = ST_ARM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Period and high-time counters, held at zero while idle.
    // per_cnt restarts after a timeout so that ARM keeps re-checking.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (!run) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            if (rise) begin
                per_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (timeout) begin
                per_cnt <= '0;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end

            if (rise) begin
                hi_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (sync_q2 && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    // Consecutive-equal-period tracking; the first period after ARM is
    // compared against zero so it always starts a fresh run
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            prev_per  <= '0;
            match_cnt <= '0;
        end else if (!run || timeout) begin
            prev_per  <= '0;
            match_cnt <= '0;
        end else if (rise) begin
            case (state_q)
                ST_TRACK: begin
                    prev_per  <= per_cnt;
                    match_cnt <= lock_hit ? '0 : match_nxt;
                end
                ST_LOCK: begin
                    prev_per <= per_cnt;
                    if (per_mismatch) begin
                        match_cnt <= '0;
                    end
                end
                default: begin
                    prev_per  <= '0;
                    match_cnt <= '0;
                end
            endcase
        end
    end

    // Registered outputs: measurement results, lock and sticky error
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            period_o  <= '0;
            high_o    <= '0;
            valid_o   <= 1'b0;
            div_num_o <= '0;
            lock_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (state_q == ST_IDLE) begin
                lock_o <= 1'b0;
                err_o  <= 1'b0;
            end else if (!meas_en_i) begin
                lock_o <= 1'b0;
            end else begin
                if (measuring && fall) begin
                    high_o <= hi_cnt;
                end
                if (measuring && rise) begin
                    period_o <= per_cnt;
                    valid_o  <= 1'b1;
                end
                if ((state_q == ST_TRACK) && rise && lock_hit) begin
                    div_num_o <= per_cnt;
                    lock_o    <= 1'b1;
                end
                if ((state_q == ST_LOCK) && rise && per_mismatch) begin
                    div_num_o <= '0;
                    lock_o    <= 1'b0;
                end
                if (timeout) begin
                    err_o     <= 1'b1;
                    lock_o    <= 1'b0;
                    div_num_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_meas.sv
// Self-checking bench for clk_div_meas: directed scenarios plus randomized
// ratios, checked against a run-length model of the lock rules.
module tb_clk_div_meas;

    localparam int unsigned CNT_W    = 8;
    localparam int          LOCK_CNT = 4;
    localparam int          TIMEOUT  = 255;

    logic             clk_i      = 1'b0;
    logic             rst_n      = 1'b0;
    logic             meas_en_i  = 1'b0;
    logic             meas_clk_i = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic [CNT_W-1:0] div_num_o;
    logic             lock_o;
    logic             err_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int per;
        int hi;
        int lk;
        int dv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model state: current run of equal periods, lock status and ratio
    int m_run;
    int m_last;
    int m_locked;
    int m_div;
    int m_have_prev;
    int m_prev_h;
    int m_prev_l;

    clk_div_meas #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .meas_en_i  (meas_en_i),
        .meas_clk_i (meas_clk_i),
        .period_o   (period_o),
        .high_o     (high_o),
        .valid_o    (valid_o),
        .div_num_o  (div_num_o),
        .lock_o     (lock_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Every completed period produces one valid_o pulse; compare it with the
    // oldest expectation
    always @(negedge clk_i) begin
        if (rst_n && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("period_o", 32'(period_o), 32'(mon_e.per));
                check("high_o", 32'(high_o), 32'(mon_e.hi));
                check("lock_o_at_valid", 32'(lock_o), 32'(mon_e.lk));
                check("div_num_o_at_valid", 32'(div_num_o), 32'(mon_e.dv));
            end
        end
    end

    task automatic session_reset();
        m_run       = 0;
        m_last      = 0;
        m_locked    = 0;
        m_have_prev = 0;
    endtask

    // A completed period of h high + l low cycles under the lock rules
    task automatic push(input int h, input int l);
        exp_t e;
        int p;
        p = h + l;
        if (m_run > 0 && p == m_last) m_run++;
        else m_run = 1;
        m_last = p;
        if (m_locked == 0) begin
            if (m_run >= LOCK_CNT) begin
                m_locked = 1;
                m_div    = p;
            end
        end else if (p != m_div) begin
            m_locked = 0;
            m_div    = 0;
            m_run    = 1;
        end
        e.per = p;
        e.hi  = h;
        e.lk  = m_locked;
        e.dv  = m_div;
        exp_q.push_back(e);
    endtask

    // One divided-clock cycle: the rise that starts it completes the previous one
    task automatic seg(input int h, input int l);
        if (m_have_prev != 0) push(m_prev_h, m_prev_l);
        m_prev_h    = h;
        m_prev_l    = l;
        m_have_prev = 1;
        meas_clk_i  = 1'b1;
        tick(h);
        meas_clk_i  = 1'b0;
        tick(l);
    endtask

    // Final rise that completes the last segment; meas_clk_i is left high
    task automatic close_seq();
        if (m_have_prev != 0) push(m_prev_h, m_prev_l);
        m_have_prev = 0;
        meas_clk_i  = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick(1);
            k++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_session();
        meas_clk_i = 1'b0;
        meas_en_i  = 1'b1;
        session_reset();
        tick(3);
    endtask

    task automatic stop_session(input string tag);
        meas_en_i = 1'b0;
        session_reset();
        tick(3);
        check({tag, "_idle_lock"}, 32'(lock_o), 32'd0);
        check({tag, "_idle_err"}, 32'(err_o), 32'd0);
        check({tag, "_idle_div_held"}, 32'(div_num_o), 32'(m_div));
    endtask

    task automatic wait_err(input string tag, input int budget);
        int k;
        k = 0;
        while (err_o !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_err_set"}, 32'(err_o), 32'd1);
        check({tag, "_err_lock"}, 32'(lock_o), 32'd0);
        check({tag, "_err_div"}, 32'(div_num_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, 32'(period_o), 32'd0);
        check({tag, "_high"}, 32'(high_o), 32'd0);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_div"}, 32'(div_num_o), 32'd0);
        check({tag, "_lock"}, 32'(lock_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int h;
        int n;
        m_div = 0;
        session_reset();

        // Reset values, during and after reset
        tick(3);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick(3);
        check_all_zero("after_reset");

        // Ratio 4, 2/2
        start_session();
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        check("r4_lock", 32'(lock_o), 32'd1);
        check("r4_div", 32'(div_num_o), 32'd4);
        check("r4_period", 32'(period_o), 32'd4);
        check("r4_high", 32'(high_o), 32'd2);
        stop_session("r4");

        // Ratio 5 (3/2) and ratio 2 (1/1)
        start_session();
        repeat (4) seg(3, 2);
        close_seq();
        drain();
        check("r5_lock", 32'(lock_o), 32'd1);
        check("r5_div", 32'(div_num_o), 32'd5);
        check("r5_high", 32'(high_o), 32'd3);
        stop_session("r5");

        start_session();
        repeat (4) seg(1, 1);
        close_seq();
        drain();
        check("r2_lock", 32'(lock_o), 32'd1);
        check("r2_div", 32'(div_num_o), 32'd2);
        check("r2_high", 32'(high_o), 32'd1);
        stop_session("r2");

        // Locked at 4 then switched to 6
        start_session();
        repeat (5) seg(2, 2);
        repeat (5) seg(3, 3);
        close_seq();
        drain();
        check("sw6_lock", 32'(lock_o), 32'd1);
        check("sw6_div", 32'(div_num_o), 32'd6);
        stop_session("sw6");

        // Jitter: periods 4,4,5,4,4,4,4
        start_session();
        seg(2, 2);
        seg(2, 2);
        seg(3, 2);
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        check("jit_lock", 32'(lock_o), 32'd1);
        check("jit_div", 32'(div_num_o), 32'd4);
        stop_session("jit");

        // Randomized constant ratios
        repeat (4) begin
            r = int'($urandom_range(20, 2));
            h = int'($urandom_range(r - 1, 1));
            n = int'($urandom_range(7, 4));
            start_session();
            repeat (n) seg(h, r - h);
            close_seq();
            drain();
            check("rnd_lock", 32'(lock_o), 32'(m_locked));
            check("rnd_div", 32'(div_num_o), 32'(m_div));
            stop_session("rnd");
        end

        // Randomized jitter between two neighbouring ratios
        repeat (2) begin
            start_session();
            repeat (14) begin
                r = 6 + (($urandom_range(3, 0) == 0) ? 1 : 0);
                h = int'($urandom_range(r - 1, 1));
                seg(h, r - h);
            end
            close_seq();
            drain();
            check("rjit_lock", 32'(lock_o), 32'(m_locked));
            check("rjit_div", 32'(div_num_o), 32'(m_div));
            stop_session("rjit");
        end

        // Static low clock: timeout from ARM, sticky until disabled
        meas_clk_i = 1'b0;
        meas_en_i  = 1'b1;
        session_reset();
        tick(TIMEOUT - 4);
        check("stat0_no_early_err", 32'(err_o), 32'd0);
        wait_err("stat0", 16);
        m_div = 0;
        tick(300);
        check("stat0_sticky", 32'(err_o), 32'd1);
        stop_session("stat0");

        // Static high clock
        meas_clk_i = 1'b1;
        tick(3);
        meas_en_i = 1'b1;
        session_reset();
        tick(TIMEOUT - 4);
        check("stat1_no_early_err", 32'(err_o), 32'd0);
        wait_err("stat1", 16);
        stop_session("stat1");

        // Timeout while locked, then re-lock with err_o still set
        start_session();
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        check("tol_lock", 32'(lock_o), 32'd1);
        tick(240);
        check("tol_no_early_err", 32'(err_o), 32'd0);
        wait_err("tol", 30);
        m_div = 0;
        session_reset();
        meas_clk_i = 1'b0;
        tick(3);
        repeat (4) seg(3, 2);
        close_seq();
        drain();
        check("tol_relock", 32'(lock_o), 32'd1);
        check("tol_relock_div", 32'(div_num_o), 32'd5);
        check("tol_err_sticky", 32'(err_o), 32'd1);
        stop_session("tol");

        // Disable mid-period
        start_session();
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        meas_clk_i = 1'b0;
        tick(1);
        meas_en_i = 1'b0;
        session_reset();
        tick(6);
        check("dis_lock", 32'(lock_o), 32'd0);
        check("dis_div_held", 32'(div_num_o), 32'd4);

        // Disable with a completed period in flight: no valid_o
        start_session();
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        meas_clk_i = 1'b0;
        tick(2);
        meas_clk_i = 1'b1;
        tick(1);
        meas_en_i = 1'b0;
        session_reset();
        tick(6);
        check("inflight_lock", 32'(lock_o), 32'd0);
        check("inflight_valid", 32'(valid_o), 32'd0);

        // Asynchronous reset while locked, then re-lock
        start_session();
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        check("rst_pre_lock", 32'(lock_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        m_div = 0;
        session_reset();
        meas_clk_i = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        repeat (4) seg(2, 2);
        close_seq();
        drain();
        check("rst_relock", 32'(lock_o), 32'd1);
        check("rst_relock_div", 32'(div_num_o), 32'd4);
        stop_session("rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
